// File: rtl/red_pitaya_asg_pkg.sv
// Shared types and constants for the ASG channel.
package red_pitaya_asg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DELAY = 2'd2,
      HOLD  = 2'd3
   } asg_state_t;

   localparam logic [15:0] INF_REP    = 16'hFFFF;
   localparam int          PIPE_DEPTH = 4;
   localparam int          SCALE_LAT  = 2;

endpackage

// File: rtl/asg_scale_sat.sv
// Gain, offset and saturation stages of the ASG output path (2-cycle latency).
module asg_scale_sat #(
   parameter int DW = 14
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [DW-1:0] i_sample,
   input  logic [DW-1:0] i_amp,
   input  logic [DW-1:0] i_dc,
   output logic [DW-1:0] o_dac
);

   localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

   logic signed [2*DW:0] w_prod;
   logic signed [DW+1:0] r_prod_hi;
   logic signed [DW+1:0] w_sum;
   logic [DW-1:0]        w_sat;
   logic [DW-1:0]        r_dac;
   logic                 w_unused_lsb;

   // Gain is unsigned, so it enters the signed multiply with a zero sign bit.
   assign w_prod = $signed({{(DW+1){i_sample[DW-1]}}, i_sample})
                 * $signed({{(DW+1){1'b0}}, i_amp});
   assign w_unused_lsb = ^w_prod[DW-2:0];

   assign w_sum = r_prod_hi + $signed({{2{i_dc[DW-1]}}, i_dc});

   always_comb begin
      if (w_sum > SAT_MAX)      w_sat = SAT_MAX[DW-1:0];
      else if (w_sum < SAT_MIN) w_sat = SAT_MIN[DW-1:0];
      else                      w_sat = w_sum[DW-1:0];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prod_hi <= '0;
         r_dac     <= '0;
      end else begin
         r_prod_hi <= w_prod[2*DW:DW-1];
         r_dac     <= w_sat;
      end
   end

   assign o_dac = r_dac;

endmodule

// File: rtl/red_pitaya_asg_gen.sv
// ASG channel: sample table, fractional pointer, burst/repeat FSM and output scaling.
// Define ASG_SWEEP_EN to enable the per-wrap frequency sweep of the pointer step.
module red_pitaya_asg_gen
   import red_pitaya_asg_pkg::*;
#(
   parameter  int DW       = 14,
   parameter  int RSZ      = 14,
   parameter  int FW       = 16,
   parameter  int TICK_DIV = 125,
   localparam int PW       = RSZ + FW
) (
   input  logic           dac_clk_i,
   input  logic           dac_rst_i,
   input  logic           trig_i,
   input  logic           buf_we_i,
   input  logic [RSZ-1:0] buf_addr_i,
   input  logic [DW-1:0]  buf_wdata_i,
   output logic [DW-1:0]  buf_rdata_o,
   output logic [RSZ-1:0] buf_rpnt_o,
   input  logic [PW-1:0]  set_size_i,
   input  logic [PW-1:0]  set_step_i,
   input  logic [PW-1:0]  set_sweep_i,
   input  logic [PW-1:0]  set_ofs_i,
   input  logic           set_wrap_i,
   input  logic           set_rst_i,
   input  logic [DW-1:0]  set_amp_i,
   input  logic [DW-1:0]  set_dc_i,
   input  logic [DW-1:0]  set_first_i,
   input  logic [DW-1:0]  set_last_i,
   input  logic           set_zero_i,
   input  logic [15:0]    set_ncyc_i,
   input  logic [15:0]    set_rnum_i,
   input  logic [31:0]    set_rdly_i,
   output logic [1:0]     state_o,
   output logic           busy_o,
   output logic           trig_done_o,
   output logic [DW-1:0]  dac_o
);

   localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SEL_DLY = PIPE_DEPTH - SCALE_LAT - 1;

   logic [DW-1:0] r_mem [2**RSZ];

   asg_state_t    r_state, w_state_nxt;
   logic [PW-1:0] r_pnt, w_pnt_nxt, w_step, w_carry;
   logic [PW:0]   w_nxt;
   logic [15:0]   r_cyc_cnt, w_cyc_nxt, r_rep_cnt, w_rep_nxt;
   logic [31:0]   r_dly_cnt, w_dly_nxt;
   logic [TW-1:0] r_tick_cnt, w_tick_nxt;
   logic          w_wrap, w_burst_start;
   logic [DW-1:0] r_tbl_rd, r_buf_rdata, r_src, w_src;
   asg_state_t    r_sel_dly [SEL_DLY];

`ifdef ASG_SWEEP_EN
   localparam logic signed [PW:0] STEP_MIN = (PW+1)'(1);
   localparam logic signed [PW:0] STEP_MAX = {2'b00, {(PW-1){1'b1}}};

   logic [PW-1:0]      r_step, w_step_swept;
   logic signed [PW:0] w_swept;

   assign w_swept = $signed({1'b0, r_step}) + $signed({set_sweep_i[PW-1], set_sweep_i});
   assign w_step_swept = (w_swept < STEP_MIN) ? STEP_MIN[PW-1:0] :
                         (w_swept > STEP_MAX) ? STEP_MAX[PW-1:0] : w_swept[PW-1:0];

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i)                      r_step <= '0;
      else if (set_rst_i || w_burst_start) r_step <= set_step_i;
      else if (r_state == RUN && w_wrap)   r_step <= w_step_swept;
   end

   assign w_step = r_step;
`else
   logic w_unused_sweep;

   assign w_step         = set_step_i;
   assign w_unused_sweep = ^set_sweep_i;
`endif

   assign w_nxt   = {1'b0, r_pnt} + {1'b0, w_step};
   assign w_wrap  = w_nxt > {1'b0, set_size_i};
   assign w_carry = w_nxt[PW-1:0] - set_size_i - PW'(1);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_pnt_nxt     = r_pnt;
      w_cyc_nxt     = r_cyc_cnt;
      w_rep_nxt     = r_rep_cnt;
      w_dly_nxt     = r_dly_cnt;
      w_tick_nxt    = r_tick_cnt;
      w_burst_start = 1'b0;
      if (set_rst_i) begin
         w_state_nxt = IDLE;
         w_pnt_nxt   = set_ofs_i;
         w_cyc_nxt   = '0;
         w_rep_nxt   = '0;
         w_dly_nxt   = '0;
         w_tick_nxt  = '0;
      end else begin
         case (r_state)
            IDLE, HOLD: begin
               if (trig_i) begin
                  w_state_nxt   = RUN;
                  w_pnt_nxt     = set_ofs_i;
                  w_cyc_nxt     = set_ncyc_i;
                  w_rep_nxt     = set_rnum_i;
                  w_burst_start = 1'b1;
               end
            end
            RUN: begin
               if (!w_wrap) begin
                  w_pnt_nxt = w_nxt[PW-1:0];
               end else if (r_cyc_cnt == 16'd1) begin
                  w_pnt_nxt = set_ofs_i;
                  if (r_rep_cnt != 16'd0) begin
                     w_state_nxt = DELAY;
                     w_dly_nxt   = set_rdly_i;
                     w_tick_nxt  = '0;
                     if (r_rep_cnt != INF_REP) w_rep_nxt = r_rep_cnt - 16'd1;
                  end else begin
                     w_state_nxt = HOLD;
                  end
               end else begin
                  w_pnt_nxt = set_wrap_i ? w_carry : set_ofs_i;
                  if (r_cyc_cnt != 16'd0) w_cyc_nxt = r_cyc_cnt - 16'd1;
               end
            end
            DELAY: begin
               if (r_dly_cnt == 32'd0) begin
                  w_state_nxt   = RUN;
                  w_cyc_nxt     = set_ncyc_i;
                  w_burst_start = 1'b1;
               end else if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
                  w_tick_nxt = '0;
                  w_dly_nxt  = r_dly_cnt - 32'd1;
                  if (r_dly_cnt == 32'd1) begin
                     w_state_nxt   = RUN;
                     w_cyc_nxt     = set_ncyc_i;
                     w_burst_start = 1'b1;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         r_state    <= IDLE;
         r_pnt      <= '0;
         r_cyc_cnt  <= '0;
         r_rep_cnt  <= '0;
         r_dly_cnt  <= '0;
         r_tick_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pnt      <= w_pnt_nxt;
         r_cyc_cnt  <= w_cyc_nxt;
         r_rep_cnt  <= w_rep_nxt;
         r_dly_cnt  <= w_dly_nxt;
         r_tick_cnt <= w_tick_nxt;
      end
   end

   // NOTE: the table has no reset so it can map onto block RAM; only its read registers are reset.
   always_ff @(posedge dac_clk_i) begin
      if (buf_we_i) r_mem[buf_addr_i] <= buf_wdata_i;
   end

   // The source select follows the table read by one stage, so the state is delayed to match.
   always_comb begin
      w_src = set_first_i;
      if (set_zero_i) begin
         w_src = '0;
      end else begin
         case (r_sel_dly[SEL_DLY-1])
            RUN:         w_src = r_tbl_rd;
            DELAY, HOLD: w_src = set_last_i;
            default:     w_src = set_first_i;
         endcase
      end
   end

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         r_tbl_rd    <= '0;
         r_buf_rdata <= '0;
         r_src       <= '0;
         for (int i = 0; i < SEL_DLY; i++) r_sel_dly[i] <= IDLE;
      end else begin
         r_tbl_rd    <= r_mem[r_pnt[PW-1:FW]];
         r_buf_rdata <= r_mem[buf_addr_i];
         r_src       <= w_src;
         r_sel_dly[0] <= r_state;
         for (int i = 1; i < SEL_DLY; i++) r_sel_dly[i] <= r_sel_dly[i-1];
      end
   end

   asg_scale_sat #(.DW(DW)) u_scale (
      .i_clk    (dac_clk_i),
      .i_rst    (dac_rst_i),
      .i_sample (r_src),
      .i_amp    (set_amp_i),
      .i_dc     (set_dc_i),
      .o_dac    (dac_o)
   );

   assign buf_rdata_o = r_buf_rdata;
   assign buf_rpnt_o  = r_pnt[PW-1:FW];
   assign state_o     = r_state;
   assign busy_o      = (r_state == RUN) || (r_state == DELAY);
   assign trig_done_o = trig_i && !set_rst_i && (r_state == IDLE || r_state == HOLD);

endmodule

// File: tb/tb_red_pitaya_asg_gen.sv
// Self-checking bench for red_pitaya_asg_gen: directed and randomized bursts against a sample-stream model.
`timescale 1ns/1ps
module tb_red_pitaya_asg_gen;
   import red_pitaya_asg_pkg::*;

   localparam int DW       = 14;
   localparam int RSZ      = 14;
   localparam int FW       = 16;
   localparam int PW       = RSZ + FW;
   localparam int TICK_DIV = 125;
   localparam int NTBL     = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           trig;
   logic           we;
   logic [RSZ-1:0] addr;
   logic [DW-1:0]  wdata;
   logic [DW-1:0]  rdata;
   logic [RSZ-1:0] rpnt;
   logic [PW-1:0]  size, step, sweep, ofs;
   logic           wrap, srst, zero;
   logic [DW-1:0]  amp, dc, first, last;
   logic [15:0]    ncyc, rnum;
   logic [31:0]    rdly;
   logic [1:0]     state;
   logic           busy, trig_done;
   logic [DW-1:0]  dac;

   int            total = 0;
   int            bad   = 0;
   int            tbl [NTBL];
   logic [DW-1:0] exp_q [$];

   always #4 clk = ~clk;

   red_pitaya_asg_gen #(.DW(DW), .RSZ(RSZ), .FW(FW), .TICK_DIV(TICK_DIV)) dut (
      .dac_clk_i   (clk),
      .dac_rst_i   (rst),
      .trig_i      (trig),
      .buf_we_i    (we),
      .buf_addr_i  (addr),
      .buf_wdata_i (wdata),
      .buf_rdata_o (rdata),
      .buf_rpnt_o  (rpnt),
      .set_size_i  (size),
      .set_step_i  (step),
      .set_sweep_i (sweep),
      .set_ofs_i   (ofs),
      .set_wrap_i  (wrap),
      .set_rst_i   (srst),
      .set_amp_i   (amp),
      .set_dc_i    (dc),
      .set_first_i (first),
      .set_last_i  (last),
      .set_zero_i  (zero),
      .set_ncyc_i  (ncyc),
      .set_rnum_i  (rnum),
      .set_rdly_i  (rdly),
      .state_o     (state),
      .busy_o      (busy),
      .trig_done_o (trig_done),
      .dac_o       (dac)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sx(input logic [DW-1:0] v);
      return v[DW-1] ? int'(v) - (1 << DW) : int'(v);
   endfunction

   // Ideal output: floor(sample * gain / 2^(DW-1)) + offset, clipped to the DAC range.
   function automatic logic [DW-1:0] scale(input int s);
      longint prod, q, sum;
      prod = longint'(s) * longint'(amp);
      q = prod / 8192;
      if (prod < 0 && (prod % 8192) != 0) q = q - 1;
      sum = q + longint'(sx(dc));
      if (sum > 8191) sum = 8191;
      else if (sum < -8192) sum = -8192;
      return DW'(sum);
   endfunction

   // Expected dac_o stream from the first table sample onward.
   function automatic void build_exp(input int tail);
      longint p, nxt, stp;
      int     wraps, reps, dl;
`ifdef ASG_SWEEP_EN
      longint sw;
      sw = sweep[PW-1] ? longint'(sweep) - (longint'(1) << PW) : longint'(sweep);
`endif
      exp_q.delete();
      p    = longint'(ofs);
      stp  = longint'(step);
      reps = int'(rnum);
      forever begin
         wraps = 0;
         forever begin
            if (exp_q.size() > 5000) return;
            exp_q.push_back(scale(tbl[int'(p >>> FW)]));
            nxt = p + stp;
            if (nxt > longint'(size)) begin
               wraps++;
`ifdef ASG_SWEEP_EN
               stp = stp + sw;
               if (stp < 1) stp = 1;
               if (stp > (longint'(1) << (PW-1)) - 1) stp = (longint'(1) << (PW-1)) - 1;
`endif
               if (ncyc != 16'd0 && wraps == int'(ncyc)) break;
               p = wrap ? nxt - longint'(size) - 1 : longint'(ofs);
            end else begin
               p = nxt;
            end
         end
         if (reps == 0) break;
         dl = (rdly == 32'd0) ? 1 : int'(rdly) * TICK_DIV;
         repeat (dl) exp_q.push_back(scale(sx(last)));
         if (reps != 16'hFFFF) reps--;
         p   = longint'(ofs);
         stp = longint'(step);
      end
      repeat (tail) exp_q.push_back(scale(sx(last)));
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tbl(input int idx, input int val);
      @(negedge clk);
      we    = 1'b1;
      addr  = RSZ'(idx);
      wdata = DW'(val);
      @(negedge clk);
      we    = 1'b0;
      tbl[idx] = sx(DW'(val));
   endtask

   task automatic load_ramp();
      for (int i = 0; i < NTBL; i++) write_tbl(i, i);
   endtask

   // Trigger, then compare dac_o every cycle against exp_q; extra trigger pulses land at poke_a/poke_b.
   task automatic run_stream(input string tag, input int poke_a, input int poke_b);
      @(negedge clk);
      trig = 1'b1;
      #1 check({tag, "_trig_done"}, 32'(trig_done), 32'd1);
      @(negedge clk);
      trig = 1'b0;
      #1 check({tag, "_state_run"}, 32'(state), 32'(RUN));
      wait_cyc(3);
      foreach (exp_q[i]) begin
         @(negedge clk);
         trig = 1'b0;
         check(tag, 32'(dac), 32'(exp_q[i]));
         if (i == poke_a || i == poke_b) begin
            trig = 1'b1;
            #1 check({tag, "_trig_ignored"}, 32'(trig_done), 32'd0);
         end
      end
      @(negedge clk);
      trig = 1'b0;
      check({tag, "_state_hold"}, 32'(state), 32'(HOLD));
      check({tag, "_busy_hold"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      trig  = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      size  = PW'(32'hFFFFF);
      step  = PW'(32'h10000);
      sweep = '0;
      ofs   = '0;
      wrap  = 1'b0;
      srst  = 1'b0;
      zero  = 1'b0;
      amp   = 14'h2000;
      dc    = '0;
      first = 14'h0100;
      last  = 14'h1FFF;
      ncyc  = 16'd2;
      rnum  = 16'd0;
      rdly  = 32'd0;

      wait_cyc(3);
      check("rst_dac", 32'(dac), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_rpnt", 32'(rpnt), 32'd0);
      check("rst_state", 32'(state), 32'(IDLE));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_trig_done", 32'(trig_done), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      wait_cyc(4);
      check("idle_first", 32'(dac), 32'h0100);

      load_ramp();
      @(negedge clk);
      addr = RSZ'(5);
      @(negedge clk);
      check("readback_5", 32'(rdata), 32'd5);
      addr = RSZ'(12);
      @(negedge clk);
      check("readback_12", 32'(rdata), 32'd12);

      // Two-cycle burst into HOLD, then a second trigger restarts it.
      build_exp(8);
      run_stream("burst", -1, -1);
      run_stream("burst_again", -1, -1);

      step = PW'(32'h8000);
      ncyc = 16'd1;
      build_exp(8);
      run_stream("half_step", -1, -1);

      step = PW'(32'h30000);
      wrap = 1'b1;
      ncyc = 16'd2;
      build_exp(8);
      run_stream("wrap_carry", -1, -1);

      // Three bursts with 3-tick gaps; triggers poked inside RUN and DELAY.
      step = PW'(32'h10000);
      wrap = 1'b0;
      ncyc = 16'd1;
      rnum = 16'd2;
      rdly = 32'd3;
      build_exp(8);
      run_stream("repeat", 10, 200);

      last = 14'h1FFF;
      amp  = 14'h3FFF;
      dc   = 14'h1000;
      wait_cyc(5);
      check("sat_pos", 32'(dac), 32'h1FFF);
      last = 14'h2000;
      dc   = 14'h3000;
      wait_cyc(5);
      check("sat_neg", 32'(dac), 32'h2000);

      zero = 1'b1;
      amp  = 14'h2000;
      dc   = 14'h0123;
      wait_cyc(5);
      check("zero_src", 32'(dac), 32'h0123);
      zero = 1'b0;

      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < NTBL; i++) write_tbl(i, int'($urandom_range(0, 16383)));
         amp   = DW'($urandom_range(0, 16383));
         dc    = DW'($urandom_range(0, 16383));
         last  = DW'($urandom_range(0, 16383));
         step  = PW'($urandom_range(32'h4000, 32'h38000));
         ofs   = PW'($urandom_range(0, 32'h3FFFF));
         sweep = PW'(int'($urandom_range(0, 32'h2000)) - 32'h1000);
         wrap  = 1'($urandom_range(0, 1));
         ncyc  = 16'($urandom_range(1, 3));
         rnum  = 16'($urandom_range(0, 1));
         rdly  = 32'($urandom_range(0, 1));
         build_exp(8);
         run_stream("random", -1, -1);
      end

      load_ramp();
      amp   = 14'h2000;
      dc    = '0;
      last  = 14'h1FFF;
      ofs   = '0;
      wrap  = 1'b0;
      rnum  = 16'd0;
      rdly  = 32'd0;
      step  = PW'(32'h10000);
      sweep = '0;
`ifdef ASG_SWEEP_EN
      sweep = PW'(32'h10000);
      ncyc  = 16'd2;
      build_exp(8);
      run_stream("sweep", -1, -1);
      sweep = '0;
`endif

      // Soft reset during a continuous run.
      ncyc  = 16'd0;
      first = 14'h0155;
      @(negedge clk);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      wait_cyc(20);
      check("cont_busy", 32'(busy), 32'd1);
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      #1 check("srst_state", 32'(state), 32'(IDLE));
      check("srst_rpnt", 32'(rpnt), 32'd0);
      wait_cyc(4);
      check("srst_first", 32'(dac), 32'h0155);
      check("srst_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/red_pitaya_asg_gen.md
# red_pitaya_asg_gen

Parametrised single-clock arbitrary signal generator channel: holds a sample table, walks it with a fractional read pointer under a burst/repetition FSM, then scales, offsets and saturates the sample for the DAC. It supersedes the fixed 14-bit channel with generic sample width, table depth and pointer fraction, an explicit state machine with a dedicated final-hold state, and an optional per-cycle frequency sweep. Sits between the ASG register bank (configuration, buffer writes, pre-selected trigger pulse) and the DAC output mux.

## Interface
- DW, 14, sample/DAC width, signed two's complement
- RSZ, 14, log2 table depth
- FW, 16, pointer fraction bits; pointer width PW = RSZ+FW
- TICK_DIV, 125, clocks per repetition-delay tick (1 us at 125 MHz)

- dac_clk_i  in  1  clock, all logic on rising edge
- dac_rst_i  in  1  reset, asynchronous, active-high
- trig_i  in  1  single-cycle trigger pulse, source already selected and debounced
- buf_we_i  in  1  table write enable
- buf_addr_i  in  RSZ  table write/read-back address
- buf_wdata_i  in  DW  table write data
- buf_rdata_o  out  DW  read-back data, 1-cycle latency
- buf_rpnt_o  out  RSZ  integer part of the current read pointer
- set_size_i  in  PW  last valid pointer value (table length × 2^FW − 1)
- set_step_i  in  PW  pointer step per clock
- set_sweep_i  in  PW  signed step increment per buffer cycle
- set_ofs_i  in  PW  start pointer
- set_wrap_i  in  1  1: carry remainder on wrap; 0: restart at set_ofs_i
- set_rst_i  in  1  synchronous soft reset of FSM and pointer
- set_amp_i  in  DW  unsigned gain; 2^(DW-1) = unity
- set_dc_i  in  DW  signed offset
- set_first_i / set_last_i  in  DW  idle value / final-hold value
- set_zero_i  in  1  force pre-scale sample to 0
- set_ncyc_i  in  16  table cycles per burst; 0 = continuous
- set_rnum_i  in  16  extra repetitions; 16'hFFFF = infinite
- set_rdly_i  in  32  delay between repetitions, in ticks
- state_o  out  2  FSM state
- busy_o  out  1  state != IDLE and state != HOLD
- trig_done_o  out  1  pulse when a trigger is accepted
- dac_o  out  DW  output sample

## Operation
- States: IDLE, RUN, DELAY, HOLD. Reset and set_rst_i → IDLE, pnt = set_ofs_i, counters cleared. set_rst_i overrides every other event in the same cycle.
- IDLE/HOLD + trig_i → RUN: pnt = set_ofs_i, cyc_cnt = set_ncyc_i, rep_cnt = set_rnum_i, trig_done_o = 1. trig_i in RUN/DELAY is ignored.
- RUN: nxt = pnt + step (PW+1 bits). If nxt > set_size_i, a wrap event occurs: pnt = set_wrap_i ? nxt − set_size_i − 1 : set_ofs_i. Otherwise pnt = nxt.
- Wrap with cyc_cnt == 1: burst ends and pnt = set_ofs_i. If rep_cnt != 0 → DELAY, with dly_cnt = set_rdly_i, tick counter cleared, and rep_cnt decremented unless it is 16'hFFFF. Otherwise → HOLD. Any other wrap decrements cyc_cnt if nonzero. set_ncyc_i = 0 never ends.
- DELAY: dly_cnt decrements every TICK_DIV clocks. When dly_cnt reaches 0 (immediately if set_rdly_i = 0), → RUN with cyc_cnt reloaded.
- Source select: RUN → table sample; DELAY/HOLD → set_last_i; IDLE → set_first_i; set_zero_i → 0 (highest priority).
- Scale: prod = sample × {0, amp}, a (2DW+1)-bit signed product. sum = prod[2DW−1:DW−1] + dc, with sign extension. Saturate to [−2^(DW−1), 2^(DW−1)−1].
- Writes and read-back use the same table; a write and a RUN read of the same address in one cycle returns old data.

## Timing
- Reset values: dac_o = 0, buf_rdata_o = 0, buf_rpnt_o = 0, state_o = IDLE, busy_o = 0, trig_done_o = 0.
- trig_i at edge t: state RUN from t+1. Output pipeline, for the pointer value at cycle n:
  - n+1: table read register
  - n+2: source mux
  - n+3: product
  - n+4: dac_o
- The first table sample therefore appears at t+5. State-derived selects are delayed to stay sample-aligned.
- trig_done_o is combinational on the accepting cycle t.

## Configuration
- ASG_SWEEP_EN defined:
  - Effective step loads set_step_i at every burst start.
  - Each wrap event in RUN adds signed set_sweep_i.
  - Result clamps to [1, 2^(PW−1)−1].
- ASG_SWEEP_EN undefined: set_sweep_i is ignored and the step equals set_step_i.

## Structure
- Package red_pitaya_asg_pkg holds:
  - asg_state_t enum: IDLE = 0, RUN = 1, DELAY = 2, HOLD = 3
  - constants: INF_REP = 16'hFFFF, pipeline depth 4
- Sub-module asg_scale_sat: the product/offset/saturate stages (DW parameter, 2-cycle latency).

## Test plan
Defaults: DW = 14, FW = 16, ramp table 0..15, set_size_i = 0xFFFFF, amp = 0x2000, dc = 0.
- Reset: assert dac_rst_i → all outputs 0. After release with first = 0x0100, dac_o = 0x0100 within 4 cycles.
- Burst: step 0x10000, ncyc = 2, rnum = 0, last = 0x1FFF, trig at t → dac_o = 0..15, 0..15 from t+5, then 0x1FFF held, HOLD, one trig_done_o. A second trig restarts the burst.
- Fractional/wrap:
  - step 0x8000 → each sample output twice.
  - wrap = 1, step 0x30000 → 0, 3, …, 15, 2, 5.
- Repetition: ncyc = 1, rnum = 2, rdly = 3 → three bursts separated by 375 clocks of set_last_i. trig_i pulses during RUN/DELAY have no effect.
- Saturation: sample 0x1FFF, amp 0x3FFF, dc 0x1000 → 0x1FFF. Sample 0x2000, amp 0x3FFF, dc 0x3000 → 0x2000.
- set_rst_i mid-RUN → IDLE next cycle, dac_o = set_first_i 4 cycles later. With ASG_SWEEP_EN, step 0x10000 and sweep 0x10000 → second table cycle reads every other sample.
